// File: rtl/lsu_if.sv
// Bundles the request/response handshake and the data-memory bus between the
// pipeline memory stage, the load/store unit and dmem.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, drdata,
    output req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, we
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, drdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, we
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns one RISC-V load/store at a time into word-aligned
// memory cycles with lane steering, extension and word-crossing splits.
module lsu (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      r_state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_lo;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_daddr;
  logic [31:0] r_dwdata;
  logic [3:0]  r_we;

  logic [7:0]  w_mask_new;
  logic [7:0]  w_mask_lat;
  logic        w_cross;
  logic [31:0] w_base_lat;

  function automatic logic is_legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Byte lanes touched across the two-word window: [3:0] low word, [7:4] high word.
  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] o);
    logic [7:0] m;
    case (f3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << o;
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] o);
    case (o)
      2'd0:    return d;
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[7:0],  d[31:8]};
    endcase
  endfunction

  function automatic logic [31:0] gather_ext(input logic [31:0] lo, input logic [31:0] hi,
                                             input logic [1:0] o, input logic [2:0] f3);
    logic [31:0] raw;
    case (o)
      2'd0:    raw = lo;
      2'd1:    raw = {hi[7:0],  lo[31:8]};
      2'd2:    raw = {hi[15:0], lo[31:16]};
      default: raw = {hi[23:0], lo[31:24]};
    endcase
    case (f3)
      3'b000:  return {{24{raw[7]}},  raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'd0, raw[7:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign w_mask_new = lane_mask(bus.req_funct3, bus.req_addr[1:0]);
  assign w_mask_lat = lane_mask(r_funct3, r_addr[1:0]);
  assign w_cross    = |w_mask_lat[7:4];
  assign w_base_lat = {r_addr[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_daddr      <= 32'd0;
      r_dwdata     <= 32'd0;
      r_we         <= 4'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_we         <= 4'd0;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_is_store <= bus.req_is_store;
          r_funct3   <= bus.req_funct3;
          r_addr     <= bus.req_addr;
          r_wdata    <= bus.req_wdata;
          if (is_legal(bus.req_is_store, bus.req_funct3)) begin
            r_state  <= ACC0;
            r_daddr  <= {bus.req_addr[31:2], 2'b00};
            r_dwdata <= rotl_bytes(bus.req_wdata, bus.req_addr[1:0]);
            r_we     <= bus.req_is_store ? w_mask_new[3:0] : 4'd0;
          end else begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= 32'd0;
          end
        end
        // ACC0: low word on the bus; capture it in case the access spills over
        ACC0: begin
          r_lo <= bus.drdata;
          if (w_cross) begin
            r_state <= ACC1;
            r_daddr <= w_base_lat + 32'd4;
            r_we    <= r_is_store ? w_mask_lat[7:4] : 4'd0;
          end else begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_is_store ? 32'd0
                          : gather_ext(bus.drdata, bus.drdata, r_addr[1:0], r_funct3);
          end
        end
        // ACC1: high word on the bus; merge with the captured low word
        ACC1: begin
          r_state      <= DONE;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= r_is_store ? 32'd0
                        : gather_ext(r_lo, bus.drdata, r_addr[1:0], r_funct3);
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE) & ~reset;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.daddr      = r_daddr;
  assign bus.dwdata     = r_dwdata;
  // A reset cycle must never commit bytes, even mid-access.
  assign bus.we         = r_we & {4{~reset}};
endmodule
